multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit that sequences one RISC-V RV32I subset instruction at a time and drives the ALU control code, datapath mux selects and write strobes. It is the initiator side of the ALU control interface: it issues 4-bit ALU operation codes and consumes the ALU `zero`/`carry` flags and the result LSB to resolve branches. It sits between the instruction register/memory port and the shared datapath (register file, ALU, PC, old-PC, ALUOut register).

## Interface
Parameters:
- `RESET_PC_HOLD`, 1: cycles spent in RESET after reset deassertion before the first fetch (>=1).

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `instr`  in  32  instruction register contents (valid from the cycle after `ir_we`)
- `mem_ready`  in  1  memory accepts/completes the current `mem_req` this cycle
- `alu_zero`  in  1  ALU equal flag
- `alu_carry`  in  1  ALU unsigned a>=b flag
- `alu_lsb`  in  1  ALU result bit 0
- `alu_ctrl`  out  4  0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SRL, 0101 SRA, 0110 SUB/compare, 0111 SLT, 1000 XOR
- `alu_a_sel`  out  2  00 rs1, 01 PC, 10 old_pc, 11 zero
- `alu_b_sel`  out  2  00 rs2, 01 immediate, 10 constant 4
- `imm_sel`  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- `ir_we`  out  1  latch instruction and old_pc
- `pc_we`  out  1  write PC
- `pc_src`  out  1  0 live ALU result, 1 ALUOut register
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  store when 1 (valid with `mem_req`)
- `reg_we`  out  1  register-file write (never asserted when rd = 0)
- `wb_sel`  out  2  00 ALUOut, 01 memory read data, 10 PC
- `illegal`  out  1  sticky: unsupported instruction decoded

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are Moore-decoded from state plus `instr`; every output is 0 in RESET and TRAP (except `illegal`=1 in TRAP).
- RESET: hold `RESET_PC_HOLD` cycles -> FETCH.
- FETCH: `mem_req`=1, ALU = PC+4 (a=01, b=10, ADD). Stay while `mem_ready`=0. On `mem_ready`: `ir_we`=1, `pc_we`=1, `pc_src`=0 -> DECODE.
- DECODE: ALU = old_pc+imm (B or J imm by opcode) into ALUOut. Unsupported opcode/funct -> TRAP; else -> EXEC.
- Supported: R 0110011, I-ALU 0010011, LOAD 0000011 (f3=010), STORE 0100011 (f3=010), BRANCH 1100011 (f3 000,001,100,101,110,111), JAL 1101111, LUI 0110111.
- R/I mapping by f3: 000 ADD (R with f7[5]=1: SUB 0110), 001 SLL, 010 SLT, 100 XOR, 101 SRL/SRA by f7[5], 110 OR, 111 AND. f3=011 (SLTU) illegal. I-shifts require imm[11:5] of 0000000 or 0100000 (SRA only), else illegal.
- EXEC: R/I -> ALU op on rs1 with rs2/imm, -> WB. LUI -> a=zero, b=U imm, ADD, -> WB. LOAD/STORE -> rs1+imm (I/S), ADD, -> MEM. JAL -> `pc_we`=1, `pc_src`=1, `reg_we`=1, `wb_sel`=10 (PC holds old_pc+4) -> FETCH. BRANCH -> compare and resolve same cycle -> FETCH.
- Branch compare: BEQ/BNE/BLTU/BGEU use `alu_ctrl`=0110; taken = `alu_zero`, !`alu_zero`, !`alu_carry`, `alu_carry`. BLT/BGE use 0111; taken = `alu_lsb`, !`alu_lsb`. Taken -> `pc_we`=1, `pc_src`=1.
- MEM: `mem_req`=1, `mem_we`=1 for store. Hold while `mem_ready`=0. Load -> WB; store -> FETCH.
- WB: `reg_we`=1 (if rd!=0), `wb_sel` 01 for load else 00 -> FETCH.
- TRAP: terminal; only reset exits.

## Timing
- Cycles per instruction with zero-wait memory: branch 3, JAL 3, R/I/LUI 4, store 4, load 5; each `mem_ready`=0 cycle adds one.
- `mem_req`/`mem_we` stay stable until the `mem_ready` cycle.
- `illegal` rises the cycle TRAP is entered and stays 1 until `rst_n` low.
- Reset mid-instruction: state forced to RESET immediately, all strobes drop asynchronously, `illegal` cleared; no partial write may complete after reset assertion.
- `instr` is sampled only in DECODE/EXEC/MEM/WB; changes during FETCH are ignored.

## Test plan
- Reset release, `mem_ready`=1 constant -> `mem_req` first high after 1 RESET cycle; `ir_we`,`pc_we` pulse in that cycle.
- `add x3,x1,x2` (0x002081B3) -> DECODE, EXEC `alu_ctrl`=0010 b_sel=00, WB `reg_we`=1 `wb_sel`=00; 4 cycles total.
- `beq x1,x2,+8` with `alu_zero`=1 -> EXEC `alu_ctrl`=0110, `pc_we`=1 `pc_src`=1; with `alu_zero`=0 -> `pc_we`=0; 3 cycles.
- `lw x5,4(x1)` with `mem_ready` low 2 MEM cycles -> `mem_req` held 3 cycles, `mem_we`=0, then WB `wb_sel`=01; 7 cycles.
- `sltu` (f3=011, 0x0020B1B3) -> TRAP, `illegal`=1 sticky, no further `mem_req`; `rst_n` pulse clears.
- `rst_n` low during MEM of a store -> `mem_req`/`mem_we` drop immediately; restart fetch cleanly.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control unit: sequences fetch/decode/execute/memory/writeback
// and drives ALU codes, datapath mux selects and write strobes for a shared datapath.
module multicycle_ctrl #(
    parameter int unsigned RESET_PC_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_lsb,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [2:0]  imm_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal
);

    localparam int unsigned CNT_W = (RESET_PC_HOLD > 1) ? $clog2(RESET_PC_HOLD) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SRA = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1000;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   hold_cnt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       rd_nz;
    logic       is_load;
    logic       legal;
    logic       br_taken;
    logic [3:0] alu_rri;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign rd_nz         = (instr[11:7] != 5'd0);
    assign is_load       = (opcode == OP_LOAD);
    assign unused_fields = ^instr[24:15];

    // Register operands are read by the datapath directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RESET;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= (state == S_RESET) ? hold_cnt + CNT_W'(1) : '0;
        end
    end

    // R/I-type ALU code; funct7[5] only selects SUB for register-register ADD
    always_comb begin
        alu_rri = ALU_ADD;
        case (funct3)
            3'b000:  alu_rri = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_rri = ALU_SLL;
            3'b010:  alu_rri = ALU_SLT;
            3'b100:  alu_rri = ALU_XOR;
            3'b101:  alu_rri = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_rri = ALU_OR;
            3'b111:  alu_rri = ALU_AND;
            default: alu_rri = ALU_ADD;
        endcase
    end

    // Supported-instruction check, evaluated in DECODE
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct3 != 3'b011) begin
                    legal = (funct7 == 7'b0000000) ||
                            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                end
            end
            OP_I: begin
                if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else                       legal = (funct3 != 3'b011);
            end
            OP_LOAD, OP_STORE: legal = (funct3 == 3'b010);
            OP_BRANCH:         legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            OP_JAL, OP_LUI:    legal = 1'b1;
            default:           legal = 1'b0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = !alu_zero;
            3'b100:  br_taken = alu_lsb;
            3'b101:  br_taken = !alu_lsb;
            3'b110:  br_taken = !alu_carry;
            3'b111:  br_taken = alu_carry;
            default: br_taken = 1'b0;
        endcase
    end

    // Next state and Moore-decoded datapath controls
    always_comb begin
        state_nxt = state;
        alu_ctrl  = ALU_AND;
        alu_a_sel = 2'b00;
        alu_b_sel = 2'b00;
        imm_sel   = 3'b000;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'b00;
        illegal   = 1'b0;
        case (state)
            S_RESET: begin
                if (hold_cnt == CNT_W'(RESET_PC_HOLD - 1)) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_a_sel = 2'b01;
                alu_b_sel = 2'b10;
                alu_ctrl  = ALU_ADD;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_a_sel = 2'b10;
                alu_b_sel = 2'b01;
                imm_sel   = (opcode == OP_JAL) ? 3'b100 : 3'b010;
                alu_ctrl  = ALU_ADD;
                state_nxt = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_ctrl  = alu_rri;
                        state_nxt = S_WB;
                    end
                    OP_I: begin
                        alu_ctrl  = alu_rri;
                        alu_b_sel = 2'b01;
                        state_nxt = S_WB;
                    end
                    OP_LUI: begin
                        alu_a_sel = 2'b11;
                        alu_b_sel = 2'b01;
                        imm_sel   = 3'b011;
                        alu_ctrl  = ALU_ADD;
                        state_nxt = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_b_sel = 2'b01;
                        imm_sel   = is_load ? 3'b000 : 3'b001;
                        alu_ctrl  = ALU_ADD;
                        state_nxt = S_MEM;
                    end
                    OP_JAL: begin
                        pc_we     = 1'b1;
                        pc_src    = 1'b1;
                        reg_we    = rd_nz;
                        wb_sel    = 2'b10;
                        state_nxt = S_FETCH;
                    end
                    OP_BRANCH: begin
                        alu_ctrl  = (funct3[2:1] == 2'b10) ? ALU_SLT : ALU_SUB;
                        pc_we     = br_taken;
                        pc_src    = br_taken;
                        state_nxt = S_FETCH;
                    end
                    default: state_nxt = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = !is_load;
                if (mem_ready) state_nxt = is_load ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_we    = rd_nz;
                wb_sel    = is_load ? 2'b01 : 2'b00;
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_nxt = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of single instructions plus reset, stall and trap sequences.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b1;
    logic        alu_zero = 1'b0;
    logic        alu_carry = 1'b0;
    logic        alu_lsb = 1'b0;
    logic [3:0]  alu_ctrl;
    logic [1:0]  alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic [2:0]  imm_sel;
    logic        ir_we;
    logic        pc_we;
    logic        pc_src;
    logic        mem_req;
    logic        mem_we;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl #(.RESET_PC_HOLD(1)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_lsb(alu_lsb),
        .alu_ctrl(alu_ctrl), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .imm_sel(imm_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .wb_sel(wb_sel),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic        fetch_sig;
    logic [19:0] all_out;
    assign fetch_sig = mem_req && !mem_we && alu_a_sel == 2'b01 && alu_b_sel == 2'b10;
    assign all_out   = {alu_ctrl, alu_a_sel, alu_b_sel, imm_sel, ir_we, pc_we, pc_src,
                        mem_req, mem_we, reg_we, wb_sel, illegal};

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [2:0]  flg;      // {zero, carry, lsb}
        logic [3:0]  ctrl;     // EXEC-cycle expectations
        logic [1:0]  a_sel;
        logic [1:0]  b_sel;
        logic [2:0]  imm;
        logic        pc_we;
        logic        pc_src;
        logic        reg_we;   // any reg_we during the instruction
        logic [1:0]  wb_sel;   // wb_sel while reg_we
        logic        mem_we;
        int          cycles;
    } vec_t;

    typedef struct {
        logic        done;
        logic        reg_we;
        logic        mem_we;
        logic        ill;
        logic        stall_bad;
        logic [1:0]  wb_sel;
        logic [10:0] dec;
        logic [12:0] exec;
        int          cycles;
        int          mem_cycles;
    } obs_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Entered at posedge+1 with the DUT in FETCH; returns at posedge+1 of the next FETCH.
    task automatic run_instr(input logic [31:0] ins, input logic [2:0] flg, input int fwait,
                             input int mwait, input int max_cyc, output obs_t o);
        int   fw, mw, k;
        logic left, is_fetch, is_mem;
        fw = fwait; mw = mwait; k = 0; left = 1'b0;
        o = '{default: '0};
        o.cycles = max_cyc;
        instr = ins;
        {alu_zero, alu_carry, alu_lsb} = flg;
        for (int c = 0; c < max_cyc; c++) begin
            is_fetch = fetch_sig;
            is_mem   = mem_req && !is_fetch;
            if (left && is_fetch) begin
                o.done = 1'b1;
                o.cycles = c;
                break;
            end
            if (is_fetch) begin
                mem_ready = (fw == 0);
                if (fw > 0) fw--;
            end else begin
                left = 1'b1;
                if (is_mem) begin
                    mem_ready = (mw == 0);
                    if (mw > 0) mw--;
                    o.mem_cycles++;
                end else begin
                    mem_ready = 1'b1;
                end
            end
            #1;
            if (is_fetch && !mem_ready && (ir_we || pc_we)) o.stall_bad = 1'b1;
            if (left) begin
                if (k == 0) o.dec = {alu_ctrl, alu_a_sel, alu_b_sel, imm_sel};
                if (k == 1) o.exec = {alu_ctrl, alu_a_sel, alu_b_sel, imm_sel, pc_we, pc_src};
                k++;
            end
            if (reg_we) begin
                o.reg_we = 1'b1;
                o.wb_sel = wb_sel;
            end
            if (mem_we) o.mem_we = 1'b1;
            if (illegal) o.ill = 1'b1;
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
    endtask

    // Pulses reset and returns at posedge+1 in FETCH.
    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] i, input logic [2:0] f,
                                input logic [3:0] c, input logic [1:0] a, input logic [1:0] b,
                                input logic [2:0] im, input logic pw, input logic ps,
                                input logic rw, input logic [1:0] ws, input logic mw, input int cy);
        vec_t v;
        v.name = n; v.ins = i; v.flg = f; v.ctrl = c; v.a_sel = a; v.b_sel = b; v.imm = im;
        v.pc_we = pw; v.pc_src = ps; v.reg_we = rw; v.wb_sel = ws; v.mem_we = mw; v.cycles = cy;
        return v;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t        o;
        logic [31:0] ill_ins [3];
        logic [10:0] exp_dec;
        logic        mem_seen;

        vecs[0]  = mk("add",    32'h002081B3, 3'b000, 4'b0010, 2'b00, 2'b00, 3'b000, 0, 0, 1, 2'b00, 0, 4);
        vecs[1]  = mk("sub",    32'h402081B3, 3'b000, 4'b0110, 2'b00, 2'b00, 3'b000, 0, 0, 1, 2'b00, 0, 4);
        vecs[2]  = mk("sra",    32'h4020D1B3, 3'b000, 4'b0101, 2'b00, 2'b00, 3'b000, 0, 0, 1, 2'b00, 0, 4);
        vecs[3]  = mk("add_x0", 32'h00208033, 3'b000, 4'b0010, 2'b00, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 4);
        vecs[4]  = mk("addi",   32'hFFF08293, 3'b000, 4'b0010, 2'b00, 2'b01, 3'b000, 0, 0, 1, 2'b00, 0, 4);
        vecs[5]  = mk("srai",   32'h4030D293, 3'b000, 4'b0101, 2'b00, 2'b01, 3'b000, 0, 0, 1, 2'b00, 0, 4);
        vecs[6]  = mk("xori",   32'h0010C293, 3'b000, 4'b1000, 2'b00, 2'b01, 3'b000, 0, 0, 1, 2'b00, 0, 4);
        vecs[7]  = mk("lui",    32'h123453B7, 3'b000, 4'b0010, 2'b11, 2'b01, 3'b011, 0, 0, 1, 2'b00, 0, 4);
        vecs[8]  = mk("sw",     32'h0020A423, 3'b000, 4'b0010, 2'b00, 2'b01, 3'b001, 0, 0, 0, 2'b00, 1, 4);
        vecs[9]  = mk("lw",     32'h0040A283, 3'b000, 4'b0010, 2'b00, 2'b01, 3'b000, 0, 0, 1, 2'b01, 0, 5);
        vecs[10] = mk("beq_t",  32'h00208463, 3'b100, 4'b0110, 2'b00, 2'b00, 3'b000, 1, 1, 0, 2'b00, 0, 3);
        vecs[11] = mk("beq_nt", 32'h00208463, 3'b000, 4'b0110, 2'b00, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 3);
        vecs[12] = mk("bne_t",  32'h00209463, 3'b000, 4'b0110, 2'b00, 2'b00, 3'b000, 1, 1, 0, 2'b00, 0, 3);
        vecs[13] = mk("blt_t",  32'h0020C463, 3'b001, 4'b0111, 2'b00, 2'b00, 3'b000, 1, 1, 0, 2'b00, 0, 3);
        vecs[14] = mk("bge_nt", 32'h0020D463, 3'b001, 4'b0111, 2'b00, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 3);
        vecs[15] = mk("bltu_t", 32'h0020E463, 3'b000, 4'b0110, 2'b00, 2'b00, 3'b000, 1, 1, 0, 2'b00, 0, 3);
        vecs[16] = mk("bgeu_nt",32'h0020F463, 3'b000, 4'b0110, 2'b00, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 3);
        vecs[17] = mk("jal_x1", 32'h010000EF, 3'b000, 4'b0000, 2'b00, 2'b00, 3'b000, 1, 1, 1, 2'b10, 0, 3);
        vecs[18] = mk("jal_x0", 32'h0100006F, 3'b000, 4'b0000, 2'b00, 2'b00, 3'b000, 1, 1, 0, 2'b00, 0, 3);
        vecs[19] = mk("or",     32'h0020E1B3, 3'b000, 4'b0001, 2'b00, 2'b00, 3'b000, 0, 0, 1, 2'b00, 0, 4);
        vecs[20] = mk("andi",   32'h0FF0F293, 3'b000, 4'b0000, 2'b00, 2'b01, 3'b000, 0, 0, 1, 2'b00, 0, 4);
        vecs[21] = mk("slt",    32'h0020A1B3, 3'b000, 4'b0111, 2'b00, 2'b00, 3'b000, 0, 0, 1, 2'b00, 0, 4);
        vecs[22] = mk("sll",    32'h002091B3, 3'b000, 4'b0011, 2'b00, 2'b00, 3'b000, 0, 0, 1, 2'b00, 0, 4);
        vecs[23] = mk("srl",    32'h0020D1B3, 3'b000, 4'b0100, 2'b00, 2'b00, 3'b000, 0, 0, 1, 2'b00, 0, 4);

        ill_ins[0] = 32'h0020B1B3;  // sltu
        ill_ins[1] = 32'h40309293;  // slli with imm[11:5]=0100000
        ill_ins[2] = 32'h00408283;  // lb

        // Reset release: one RESET cycle, then fetch with ir_we/pc_we
        #2;
        check("reset_outputs", 32'(all_out), 32'h0);
        #10;
        rst_n = 1'b1;
        #1;
        check("reset_hold_no_req", 32'(mem_req), 32'h0);
        @(posedge clk);
        #1;
        check("first_fetch", 32'({mem_req, ir_we, pc_we, pc_src, alu_a_sel, alu_b_sel, alu_ctrl}),
              32'({1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 4'b0010}));

        // Table of single instructions with zero-wait memory
        foreach (vecs[i]) begin
            run_instr(vecs[i].ins, vecs[i].flg, 0, 0, 20, o);
            exp_dec = {4'b0010, 2'b10, 2'b01, (vecs[i].ins[6:0] == 7'b1101111) ? 3'b100 : 3'b010};
            check({vecs[i].name, "_done"}, 32'(o.done), 32'h1);
            check({vecs[i].name, "_decode"}, 32'(o.dec), 32'(exp_dec));
            check({vecs[i].name, "_exec"}, 32'(o.exec),
                  32'({vecs[i].ctrl, vecs[i].a_sel, vecs[i].b_sel, vecs[i].imm,
                       vecs[i].pc_we, vecs[i].pc_src}));
            check({vecs[i].name, "_regwb"}, 32'({o.reg_we, o.wb_sel}),
                  32'({vecs[i].reg_we, vecs[i].wb_sel}));
            check({vecs[i].name, "_mem_we"}, 32'(o.mem_we), 32'(vecs[i].mem_we));
            check({vecs[i].name, "_cycles"}, 32'(o.cycles), 32'(vecs[i].cycles));
            if (!o.done) do_reset();
        end

        // Load with two memory wait cycles
        run_instr(32'h0040A283, 3'b000, 0, 2, 20, o);
        check("lw_wait_cycles", 32'(o.cycles), 32'd7);
        check("lw_wait_memreq", 32'(o.mem_cycles), 32'd3);
        check("lw_wait_regwb", 32'({o.reg_we, o.wb_sel, o.mem_we}), 32'({1'b1, 2'b01, 1'b0}));
        if (!o.done) do_reset();

        // Store with one wait cycle
        run_instr(32'h0020A423, 3'b000, 0, 1, 20, o);
        check("sw_wait_cycles", 32'(o.cycles), 32'd5);
        check("sw_wait_memreq", 32'({o.mem_cycles[3:0], o.mem_we, o.reg_we}), 32'({4'd2, 1'b1, 1'b0}));
        if (!o.done) do_reset();

        // Fetch stalled two cycles: no IR/PC write until ready
        run_instr(32'h002081B3, 3'b000, 2, 0, 20, o);
        check("fetch_stall_cycles", 32'(o.cycles), 32'd6);
        check("fetch_stall_strobes", 32'(o.stall_bad), 32'h0);
        if (!o.done) do_reset();

        // Illegal encodings trap; illegal is sticky and only reset clears it
        foreach (ill_ins[i]) begin
            run_instr(ill_ins[i], 3'b000, 0, 0, 8, o);
            mem_seen = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (mem_req || reg_we || pc_we) mem_seen = 1'b1;
                @(posedge clk);
                #1;
            end
            check($sformatf("trap%0d_no_return", i), 32'(o.done), 32'h0);
            check($sformatf("trap%0d_illegal", i), 32'({o.ill, illegal}), 32'h3);
            check($sformatf("trap%0d_quiet", i), 32'({mem_seen, o.mem_cycles[3:0]}), 32'h0);
            rst_n = 1'b0;
            #1;
            check($sformatf("trap%0d_reset_clears", i), 32'(all_out), 32'h0);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("trap%0d_refetch", i), 32'({fetch_sig, ir_we}), 32'h3);
        end

        // Reset asserted while a store is stalled in MEM
        instr = 32'h0020A423;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1;
        check("store_in_mem", 32'({mem_req, mem_we}), 32'h3);
        #1;
        rst_n = 1'b0;
        #1;
        check("store_reset_drop", 32'(all_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("store_reset_hold", 32'({mem_req, mem_we}), 32'h0);
        @(posedge clk);
        #1;
        check("store_reset_refetch", 32'({fetch_sig, ir_we, pc_we}), 32'h7);
        run_instr(32'h002081B3, 3'b000, 0, 0, 20, o);
        check("post_reset_add_cycles", 32'(o.cycles), 32'd4);
        check("post_reset_add_wb", 32'({o.reg_we, o.wb_sel, o.mem_we}), 32'({1'b1, 2'b00, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
